pcpi_arbiter: RTL and testbench
===============================

# pcpi_arbiter

Sequencer and arbiter between the CPU's single PCPI port and the four PCPI coprocessors (mul, div, exact_mul, approx_mul). Broadcasts each new PCPI request, grants the first coprocessor that claims it, isolates the losers, and returns one registered result to the CPU. Replaces ad-hoc per-coprocessor wiring inside `cpu`. Sits in `user_project_wrapper` between `cpu_inst_0` and the `pcpi_*` instances.

## Interface
- `N_COP`, 4: coprocessor count; index 0 has highest priority.
- `TIMEOUT`, 32: maximum BUSY cycles; used only with `PCPI_ARB_TIMEOUT_EN`.
- `clk` in 1: clock. Driven from `io_in[8]` like the rest of the core.
- `resetn` in 1: **asynchronous, active-low reset**.
- `pcpi_valid` in 1: request from the CPU.
- `pcpi_wr` out 1: result-valid to the CPU, registered.
- `pcpi_rd` out 32: result data, registered.
- `pcpi_wait` out 1: busy indication to the CPU, registered.
- `pcpi_ready` out 1: completion pulse to the CPU, registered.
- `cop_valid` out N_COP: per-coprocessor valid.
- `cop_wr` in N_COP: per-coprocessor result-valid.
- `cop_rd` in 32*N_COP: per-coprocessor result; slice i is `[32*i+31:32*i]`.
- `cop_wait` in N_COP: per-coprocessor claim/busy.
- `cop_ready` in N_COP: per-coprocessor completion.
- `grant` out N_COP: one-hot index of the current owner; 0 when no owner.
- `err_multi` out 1: sticky flag; two or more coprocessors claimed in the same cycle.
- `err_timeout` out 1: sticky flag; BUSY timeout fired.
- `err_clr` in 1: synchronous clear of both sticky flags.
- `op_count` out 16: completed responses; saturates at 16'hFFFF.

`insn`, `rs1` and `rs2` go from the CPU to the coprocessors directly and do not pass through this block.

## Operation
- Reset values: every output is 0. The FSM is in IDLE.
- Claim of coprocessor i: `cop_wait[i] | cop_ready[i]`.
- IDLE
  - `cop_valid = {N_COP{pcpi_valid}}`, which is combinational.
  - On the first claim, `grant` takes the lowest claiming index.
  - If the winner's `cop_ready` is already high, capture its wr/rd and go to RESP.
  - Otherwise go to BUSY.
  - If more than one coprocessor claimed, set `err_multi`.
  - With no claim, stay in IDLE. The CPU's own illegal-instruction timeout handles that case.
- BUSY
  - `cop_valid = grant & {N_COP{pcpi_valid}}`; the losers see valid drop in the cycle after the claim.
  - `pcpi_wait = 1`.
  - On `cop_ready[g]`, capture `cop_wr[g]` and `cop_rd[g]` and go to RESP.
  - `cop_ready` on a non-granted index is ignored.
- RESP
  - `pcpi_ready = 1` for exactly one cycle; `pcpi_wr`/`pcpi_rd` hold the captured values in that cycle.
  - `cop_valid = 0`.
  - `op_count` increments (saturating).
  - Next state is DRAIN.
- DRAIN
  - `cop_valid = 0`, `pcpi_wr`/`pcpi_rd` return to 0.
  - Stay until `pcpi_valid = 0`, then go to IDLE. This prevents the same request being re-broadcast.
- Abort: if `pcpi_valid` falls in BUSY, go to IDLE with no response and no count, and clear `grant`.
- `err_clr` in the same cycle as a new error: set wins.
- Async reset mid-transaction forces IDLE immediately. The coprocessors see `cop_valid = 0` from the same edge.

## Timing
- Claim at cycle t: `grant` and `pcpi_wait` are high from t+1.
- `cop_ready[g]` at cycle t: `pcpi_ready` is high at t+1.
- Single-cycle coprocessor (claim and ready both at t): `pcpi_ready` at t+1, and BUSY is never entered.
- The earliest next broadcast is the first cycle of IDLE after `pcpi_valid` has been low for at least one cycle.
- `pcpi_wait` is 0 in IDLE, RESP and DRAIN.

## Configuration
- With `PCPI_ARB_TIMEOUT_EN` defined:
  - A BUSY-cycle counter is reset on entry to BUSY.
  - When it reaches `TIMEOUT` with no `cop_ready[g]`: go to RESP with `pcpi_wr = 0` and `pcpi_rd = 0`, set `err_timeout`, and do not increment `op_count`.
  - A `cop_ready[g]` in the same cycle as expiry wins; it is treated as a normal completion.
- Without the macro: there is no counter, BUSY waits indefinitely, and `err_timeout` is tied to 0.

## Test plan
- Mul path:
  - Stimulus: `pcpi_valid = 1`. Coprocessor 0 asserts wait at t, then ready at t+3 with `wr = 1`, `rd = 32'h0000_0032`.
  - Required: `grant = 4'b0001` at t+1; `pcpi_ready` and `pcpi_rd = 32'h32` at t+4; `op_count = 1`.
- Single-cycle claim:
  - Stimulus: coprocessor 3 asserts wait and ready in the same cycle with `rd = 32'hDEAD_BEEF`.
  - Required: `pcpi_ready` next cycle with that data; BUSY is never entered.
- Dual claim:
  - Stimulus: coprocessors 1 and 2 assert wait in the same cycle.
  - Required: `grant = 4'b0010`; `cop_valid[2]` is 0 from the next cycle; `err_multi = 1`. After `err_clr`, `err_multi = 0`.
- Abort:
  - Stimulus: `pcpi_valid` drops in BUSY.
  - Required: FSM returns to IDLE, `grant = 0`, no `pcpi_ready`, `op_count` unchanged.
- Timeout (`TIMEOUT = 8`, macro defined):
  - Stimulus: coprocessor 1 waits forever.
  - Required: `pcpi_ready` with `pcpi_wr = 0` after 8 BUSY cycles; `err_timeout = 1`. Without the macro, `pcpi_ready` never asserts.
- Reset mid-BUSY:
  - Stimulus: assert `resetn = 0` while in BUSY.
  - Required: all outputs are 0 asynchronously; the next request is arbitrated normally.

Source files
------------

// File: rtl/pcpi_arbiter_if.sv
// PCPI bus bundle: the CPU-side request/response and the per-coprocessor fan-out.
// slave = arbiter view (receives the CPU request, drives coprocessor valids).
// master = environment view (CPU plus coprocessors).
interface pcpi_arbiter_if #(
  parameter int N_COP = 4
);
  logic                 pcpi_valid;
  logic                 pcpi_wr;
  logic [31:0]          pcpi_rd;
  logic                 pcpi_wait;
  logic                 pcpi_ready;
  logic [N_COP-1:0]     cop_valid;
  logic [N_COP-1:0]     cop_wr;
  logic [32*N_COP-1:0]  cop_rd;
  logic [N_COP-1:0]     cop_wait;
  logic [N_COP-1:0]     cop_ready;

  modport slave (
    input  pcpi_valid, cop_wr, cop_rd, cop_wait, cop_ready,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, cop_valid
  );

  modport master (
    output pcpi_valid, cop_wr, cop_rd, cop_wait, cop_ready,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, cop_valid
  );
endinterface

// File: rtl/pcpi_arbiter.sv
// PCPI arbiter: broadcasts a CPU request, grants the lowest-index claimer, returns one registered result.
// Latency: claim -> grant/pcpi_wait next cycle; cop_ready[g] -> pcpi_ready next cycle (single-cycle claim skips BUSY).
// Backpressure: CPU holds pcpi_valid until pcpi_ready; DRAIN waits for pcpi_valid low. Macro PCPI_ARB_TIMEOUT_EN adds a BUSY timeout.
module pcpi_arbiter #(
  parameter int N_COP   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              resetn,
  pcpi_arbiter_if.slave     bus,
  input  logic              err_clr,
  output logic [N_COP-1:0]  grant,
  output logic              err_multi,
  output logic              err_timeout,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [N_COP-1:0]    r_grant;
  logic                r_pcpi_wr;
  logic [31:0]         r_pcpi_rd;
  logic                r_pcpi_wait;
  logic                r_pcpi_ready;
  logic                r_err_multi;
  logic                r_err_timeout;
  logic [15:0]         r_op_count;

  logic [N_COP-1:0]    w_claim;
  logic [N_COP-1:0]    w_first;
  logic                w_any;
  logic                w_multi;
  logic [N_COP-1:0]    w_sel;
  logic                w_sel_ready;
  logic                w_sel_wr;
  logic [31:0]         w_sel_rd;
  logic [N_COP-1:0]    w_cop_valid;
  logic                w_expire;
  logic [15:0]         w_op_next;

  // Claims only mean something while a request is on the bus; a stale wait
  // left over from an aborted request must not start a new arbitration.
  always_comb begin
    w_claim = (bus.cop_wait | bus.cop_ready) & {N_COP{bus.pcpi_valid}};
    w_any   = |w_claim;
    w_multi = ($countones(w_claim) > 1);
  end

  // Fixed priority: the lowest claiming index wins.
  always_comb begin
    w_first = '0;
    for (int i = N_COP - 1; i >= 0; i--) begin
      if (w_claim[i]) begin
        w_first    = '0;
        w_first[i] = 1'b1;
      end
    end
  end

  // Response mux: in IDLE look at the would-be winner, otherwise only the owner.
  always_comb begin
    w_sel       = (r_state == S_IDLE) ? w_first : r_grant;
    w_sel_ready = |(w_sel & bus.cop_ready);
    w_sel_wr    = |(w_sel & bus.cop_wr);
    w_sel_rd    = '0;
    for (int i = 0; i < N_COP; i++) begin
      if (w_sel[i]) begin
        w_sel_rd = w_sel_rd | bus.cop_rd[32*i +: 32];
      end
    end
  end

  // Coprocessor valids: broadcast in IDLE, owner only in BUSY, none otherwise.
  // Gated by resetn so the fan-out drops on the reset edge itself.
  always_comb begin
    case (r_state)
      S_IDLE:  w_cop_valid = {N_COP{bus.pcpi_valid}};
      S_BUSY:  w_cop_valid = r_grant & {N_COP{bus.pcpi_valid}};
      default: w_cop_valid = '0;
    endcase
    w_cop_valid = w_cop_valid & {N_COP{resetn}};
  end

  // Saturating completion count.
  always_comb begin
    w_op_next = (r_op_count == 16'hFFFF) ? r_op_count : (r_op_count + 16'd1);
  end

`ifdef PCPI_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_busy_cnt;

  // BUSY-cycle counter: zero outside BUSY, so it restarts on every BUSY entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy_cnt <= '0;
    end else if (r_state != S_BUSY) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + 1'b1;
    end
  end

  assign w_expire = (r_state == S_BUSY) && (r_busy_cnt == CW'(TIMEOUT - 1));
`else
  assign w_expire = 1'b0;
`endif

  // Main sequencer: IDLE -> (BUSY) -> RESP -> DRAIN -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_pcpi_wr     <= 1'b0;
      r_pcpi_rd     <= '0;
      r_pcpi_wait   <= 1'b0;
      r_pcpi_ready  <= 1'b0;
      r_err_multi   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_op_count    <= '0;
    end else begin
      // Clear first; any set below in the same cycle overrides it.
      if (err_clr) begin
        r_err_multi   <= 1'b0;
        r_err_timeout <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_first;
            if (w_multi) begin
              r_err_multi <= 1'b1;
            end
            if (w_sel_ready) begin
              r_pcpi_wr    <= w_sel_wr;
              r_pcpi_rd    <= w_sel_rd;
              r_pcpi_ready <= 1'b1;
              r_op_count   <= w_op_next;
              r_state      <= S_RESP;
            end else begin
              r_pcpi_wait  <= 1'b1;
              r_state      <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          if (!bus.pcpi_valid) begin
            // CPU withdrew the request: no response, no count.
            r_grant     <= '0;
            r_pcpi_wait <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_sel_ready) begin
            r_pcpi_wr    <= w_sel_wr;
            r_pcpi_rd    <= w_sel_rd;
            r_pcpi_ready <= 1'b1;
            r_pcpi_wait  <= 1'b0;
            r_op_count   <= w_op_next;
            r_state      <= S_RESP;
          end else if (w_expire) begin
            // Owner never finished: complete with an empty result.
            r_pcpi_wr     <= 1'b0;
            r_pcpi_rd     <= '0;
            r_pcpi_ready  <= 1'b1;
            r_pcpi_wait   <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= S_RESP;
          end
        end

        S_RESP: begin
          r_pcpi_ready <= 1'b0;
          r_pcpi_wr    <= 1'b0;
          r_pcpi_rd    <= '0;
          r_grant      <= '0;
          r_state      <= S_DRAIN;
        end

        default: begin
          // DRAIN: the CPU may still hold pcpi_valid for the finished request.
          if (!bus.pcpi_valid) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cop_valid  = w_cop_valid;
  assign bus.pcpi_wr    = r_pcpi_wr;
  assign bus.pcpi_rd    = r_pcpi_rd;
  assign bus.pcpi_wait  = r_pcpi_wait;
  assign bus.pcpi_ready = r_pcpi_ready;
  assign grant          = r_grant;
  assign err_multi      = r_err_multi;
  assign err_timeout    = r_err_timeout;
  assign op_count       = r_op_count;

endmodule

// File: tb/tb_pcpi_arbiter.sv
// Bench for pcpi_arbiter: directed transactions push expected responses into a
// queue; a monitor pops one entry on every pcpi_ready and compares it.
module tb_pcpi_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          resetn;
  logic          err_clr;
  logic [N-1:0]  grant;
  logic          err_multi;
  logic          err_timeout;
  logic [15:0]   op_count;

  pcpi_arbiter_if #(.N_COP(N)) bus ();

  pcpi_arbiter #(.N_COP(N), .TIMEOUT(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus.slave),
    .err_clr     (err_clr),
    .grant       (grant),
    .err_multi   (err_multi),
    .err_timeout (err_timeout),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [31:0] rd, input logic [15:0] cnt);
    exp_t e;
    e.wr = wr; e.rd = rd; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic clear_cops();
    bus.cop_wait  = '0;
    bus.cop_ready = '0;
    bus.cop_wr    = '0;
    bus.cop_rd    = '0;
  endtask

  // Response monitor: every pcpi_ready must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && bus.pcpi_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: got pcpi_ready=1 expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_wr",  {31'd0, bus.pcpi_wr}, {31'd0, e.wr});
        chk("resp_rd",  bus.pcpi_rd, e.rd);
        chk("resp_cnt", {16'd0, op_count}, {16'd0, e.cnt});
      end
    end
  end

  initial begin
    resetn = 1'b0;
    err_clr = 1'b0;
    bus.pcpi_valid = 1'b0;
    clear_cops();

    // Reset state
    step(); step();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_wait",  {31'd0, bus.pcpi_wait}, 32'd0);
    chk("rst_ready", {31'd0, bus.pcpi_ready}, 32'd0);
    chk("rst_rd",    bus.pcpi_rd, 32'd0);
    chk("rst_cnt",   {16'd0, op_count}, 32'd0);
    chk("rst_errs",  {30'd0, err_multi, err_timeout}, 32'd0);
    resetn = 1'b1;
    step();

    // Mul path: cop0 waits at t, ready at t+3
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[0] = 1'b1;
    #1;
    chk("mul_bcast", {28'd0, bus.cop_valid}, 32'hF);
    step();                                          // t+1
    chk("mul_grant", {28'd0, grant}, 32'h1);
    chk("mul_wait",  {31'd0, bus.pcpi_wait}, 32'd1);
    chk("mul_copv",  {28'd0, bus.cop_valid}, 32'h1);
    step();                                          // t+2
    step();                                          // t+3
    chk("mul_noready", {31'd0, bus.pcpi_ready}, 32'd0);
    bus.cop_ready[0] = 1'b1;
    bus.cop_wr[0] = 1'b1;
    bus.cop_rd[31:0] = 32'h0000_0032;
    push(1'b1, 32'h0000_0032, 16'd1);
    step();                                          // t+4: RESP
    chk("mul_ready", {31'd0, bus.pcpi_ready}, 32'd1);
    chk("mul_resp_nowait", {31'd0, bus.pcpi_wait}, 32'd0);
    clear_cops();
    step();                                          // DRAIN, valid still high
    chk("drain_rd",   bus.pcpi_rd, 32'd0);
    chk("drain_copv", {28'd0, bus.cop_valid}, 32'd0);
    bus.pcpi_valid = 1'b0;
    step();
    step();

    // Single-cycle claim on cop3
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[3] = 1'b1;
    bus.cop_ready[3] = 1'b1;
    bus.cop_wr[3] = 1'b1;
    bus.cop_rd[127:96] = 32'hDEAD_BEEF;
    push(1'b1, 32'hDEAD_BEEF, 16'd2);
    step();
    chk("sc_nobusy", {31'd0, bus.pcpi_wait}, 32'd0);
    chk("sc_grant",  {28'd0, grant}, 32'h8);
    clear_cops();
    bus.pcpi_valid = 1'b0;
    step();
    step();

    // Dual claim: cop1 and cop2
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[1] = 1'b1;
    bus.cop_wait[2] = 1'b1;
    step();
    chk("dual_grant", {28'd0, grant}, 32'h2);
    chk("dual_copv",  {28'd0, bus.cop_valid}, 32'h2);
    chk("dual_multi", {31'd0, err_multi}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("dual_clr", {31'd0, err_multi}, 32'd0);
    bus.cop_wait[2] = 1'b0;
    bus.cop_ready[2] = 1'b1;                          // non-owner ready is ignored
    bus.cop_rd[95:64] = 32'h2222_2222;
    step();
    chk("dual_ign_ready", {31'd0, bus.pcpi_ready}, 32'd0);
    chk("dual_ign_wait",  {31'd0, bus.pcpi_wait}, 32'd1);
    bus.cop_ready[1] = 1'b1;
    bus.cop_wr[1] = 1'b1;
    bus.cop_rd[63:32] = 32'h1111_1111;
    push(1'b1, 32'h1111_1111, 16'd3);
    step();
    clear_cops();
    bus.pcpi_valid = 1'b0;
    step();
    step();

    // Abort in BUSY
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[0] = 1'b1;
    step();
    step();
    bus.pcpi_valid = 1'b0;
    step();
    chk("abort_grant", {28'd0, grant}, 32'd0);
    chk("abort_wait",  {31'd0, bus.pcpi_wait}, 32'd0);
    chk("abort_cnt",   {16'd0, op_count}, 32'd3);
    clear_cops();
    step();

    // Owner never completes
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[1] = 1'b1;
`ifdef PCPI_ARB_TIMEOUT_EN
    push(1'b0, 32'd0, 16'd3);
`endif
    step();                                          // t+1, first BUSY cycle
    for (int i = 0; i < 7; i++) step();              // t+8
    chk("to_not_yet", {31'd0, bus.pcpi_ready}, 32'd0);
    step();                                          // t+9
`ifdef PCPI_ARB_TIMEOUT_EN
    chk("to_ready", {31'd0, bus.pcpi_ready}, 32'd1);
    chk("to_err",   {31'd0, err_timeout}, 32'd1);
`else
    for (int i = 0; i < 20; i++) step();
    chk("to_still_wait", {31'd0, bus.pcpi_wait}, 32'd1);
    chk("to_err_tied",   {31'd0, err_timeout}, 32'd0);
`endif
    bus.pcpi_valid = 1'b0;
    step();
    step();
    clear_cops();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", {31'd0, err_timeout}, 32'd0);

    // Async reset while BUSY
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[2] = 1'b1;
    step();
    chk("rb_busy", {31'd0, bus.pcpi_wait}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rb_grant", {28'd0, grant}, 32'd0);
    chk("rb_wait",  {31'd0, bus.pcpi_wait}, 32'd0);
    chk("rb_copv",  {28'd0, bus.cop_valid}, 32'd0);
    chk("rb_cnt",   {16'd0, op_count}, 32'd0);
    bus.pcpi_valid = 1'b0;
    clear_cops();
    step();
    resetn = 1'b1;
    step();
    bus.pcpi_valid = 1'b1;
    bus.cop_wait[0] = 1'b1;
    bus.cop_ready[0] = 1'b1;
    bus.cop_wr[0] = 1'b1;
    bus.cop_rd[31:0] = 32'h0000_0055;
    push(1'b1, 32'h0000_0055, 16'd1);
    step();
    chk("rb_new_grant", {28'd0, grant}, 32'h1);
    clear_cops();
    bus.pcpi_valid = 1'b0;
    step();
    step();
    step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
